hcsr04_sensor_emulator: RTL and testbench

- Synthesizable responder model of the HC-SR04 ultrasonic sensor. It is the other end of the trigger/echo protocol driven by the sensor interface.
- Accepts a trigger pulse, checks its minimum width, waits a fixed burst delay, then drives echo high for a duration proportional to a programmed distance in cm.
- Used on-FPGA and in benches to exercise the interface without a physical sensor, including its timeout/retrigger path via a no-echo mode.

---
 rtl/hcsr04_sensor_emulator.sv | 194 +++++++++++++++++++
 tb/tb_hcsr04_sensor_emulator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_sensor_emulator.sv
// HC-SR04 responder: validates trigger width, waits a burst delay, then drives an
// echo pulse whose width encodes the programmed distance in cm.
module hcsr04_sensor_emulator #(
    parameter int TRIG_MIN_CYCLES = 500,
    parameter int BURST_CYCLES    = 10000,
    parameter int CYCLES_PER_CM   = 2941,
    parameter int MAX_CM          = 400,
    parameter int TIMEOUT_CYCLES  = 1900000,
    parameter int HOLDOFF_CYCLES  = 50000,
    parameter int CW              = 22
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distancia,
    input  logic       sem_eco,
    output logic       echo,
    output logic       ocupado,
    output logic       erro_trigger,
    output logic [3:0] db_estado
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_ECHO  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [CW-1:0] L_ONE        = CW'(1);
    localparam logic [CW-1:0] L_TRIG_MIN   = CW'(TRIG_MIN_CYCLES);
    localparam logic [CW-1:0] L_BURST_LAST = CW'(BURST_CYCLES - 1);
    localparam logic [CW-1:0] L_CM_LAST    = CW'(CYCLES_PER_CM - 1);
    localparam logic [CW-1:0] L_TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] L_HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [8:0]    L_MAX_CM     = 9'(MAX_CM);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [8:0]    r_dist;
    logic [8:0]    r_cm;
    logic          r_sem_eco;
    logic          r_echo;
    logic          r_ocupado;
    logic          r_erro;
    logic          w_oor;
    logic          w_trig_ok;
    logic          w_echo_d;
    logic          w_ocupado_d;
    logic          w_erro_d;

    assign w_oor     = (r_dist == 9'd0) || (r_dist > L_MAX_CM);
    assign w_trig_ok = (r_cnt >= L_TRIG_MIN);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (trigger) w_next = S_TRIG;
                else         w_next = S_IDLE;
            end
            S_TRIG: begin
                if (trigger)        w_next = S_TRIG;
                else if (w_trig_ok) w_next = S_BURST;
                else                w_next = S_IDLE;
            end
            S_BURST: begin
                if (r_cnt == L_BURST_LAST) w_next = r_sem_eco ? S_HOLD : S_ECHO;
                else                       w_next = S_BURST;
            end
            S_ECHO: begin
                // Out-of-range distances use the flat timeout; otherwise one cm per prescaler wrap.
                if (w_oor) begin
                    if (r_cnt == L_TO_LAST) w_next = S_HOLD;
                    else                    w_next = S_ECHO;
                end else begin
                    if ((r_cnt == L_CM_LAST) && (r_cm == 9'd1)) w_next = S_HOLD;
                    else                                        w_next = S_ECHO;
                end
            end
            S_HOLD: begin
                if (r_cnt == L_HOLD_LAST) w_next = S_IDLE;
                else                      w_next = S_HOLD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic, evaluated for the state being entered so outputs can be registered
    always_comb begin
        w_echo_d    = (w_next == S_ECHO);
        w_ocupado_d = (w_next != S_IDLE);
        if ((r_state == S_TRIG) && !trigger && !w_trig_ok) w_erro_d = 1'b1;
        else                                               w_erro_d = 1'b0;
    end

    // Registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_echo    <= 1'b0;
            r_ocupado <= 1'b0;
            r_erro    <= 1'b0;
        end else begin
            r_echo    <= w_echo_d;
            r_ocupado <= w_ocupado_d;
            r_erro    <= w_erro_d;
        end
    end

    // Width counter, phase counters, cm down-counter and measurement latch
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_dist    <= 9'd0;
            r_cm      <= 9'd0;
            r_sem_eco <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (trigger) r_cnt <= L_ONE;
                    else         r_cnt <= '0;
                end
                S_TRIG: begin
                    if (trigger) begin
                        if (r_cnt < L_TRIG_MIN) r_cnt <= r_cnt + L_ONE;
                        else                    r_cnt <= r_cnt;
                    end else begin
                        r_cnt <= '0;
                        if (w_trig_ok) begin
                            r_dist    <= distancia;
                            r_sem_eco <= sem_eco;
                        end else begin
                            r_dist    <= r_dist;
                            r_sem_eco <= r_sem_eco;
                        end
                    end
                end
                S_BURST: begin
                    if (r_cnt == L_BURST_LAST) begin
                        r_cnt <= '0;
                        r_cm  <= r_dist;
                    end else begin
                        r_cnt <= r_cnt + L_ONE;
                    end
                end
                S_ECHO: begin
                    if (w_oor) begin
                        if (r_cnt == L_TO_LAST) r_cnt <= '0;
                        else                    r_cnt <= r_cnt + L_ONE;
                    end else if (r_cnt == L_CM_LAST) begin
                        r_cnt <= '0;
                        r_cm  <= r_cm - 9'd1;
                    end else begin
                        r_cnt <= r_cnt + L_ONE;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == L_HOLD_LAST) r_cnt <= '0;
                    else                      r_cnt <= r_cnt + L_ONE;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Debug state code; any illegal encoding shows as 1110
    always_comb begin
        case (r_state)
            S_IDLE:  db_estado = 4'b0000;
            S_TRIG:  db_estado = 4'b0001;
            S_BURST: db_estado = 4'b0010;
            S_ECHO:  db_estado = 4'b0011;
            S_HOLD:  db_estado = 4'b0100;
            default: db_estado = 4'b1110;
        endcase
    end

    assign echo         = r_echo;
    assign ocupado      = r_ocupado;
    assign erro_trigger = r_erro;

endmodule

// File: tb/tb_hcsr04_sensor_emulator.sv
// Directed bench for hcsr04_sensor_emulator with reduced timing parameters.
module tb_hcsr04_sensor_emulator;

    logic       clock;
    logic       reset;
    logic       trigger;
    logic [8:0] distancia;
    logic       sem_eco;
    logic       echo;
    logic       ocupado;
    logic       erro_trigger;
    logic [3:0] db_estado;

    int checks   = 0;
    int failures = 0;

    hcsr04_sensor_emulator #(
        .TRIG_MIN_CYCLES(10),
        .BURST_CYCLES   (20),
        .CYCLES_PER_CM  (4),
        .MAX_CM         (400),
        .TIMEOUT_CYCLES (2000),
        .HOLDOFF_CYCLES (50),
        .CW             (22)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .trigger     (trigger),
        .distancia   (distancia),
        .sem_eco     (sem_eco),
        .echo        (echo),
        .ocupado     (ocupado),
        .erro_trigger(erro_trigger),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // n high samples of trigger, then trigger low; the next tick is the fall-sample edge
    task automatic pulse_trigger(input int n);
        trigger = 1'b1;
        repeat (n) tick();
        trigger = 1'b0;
    endtask

    task automatic wait_echo_rise(input int bound, output int n);
        n = 0;
        while (echo !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic measure_width(input int bound, output int w);
        w = 0;
        while (echo === 1'b1 && w < bound) begin
            w++;
            tick();
        end
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (db_estado !== 4'b0000 && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (echo !== 1'b0 || ocupado !== 1'b0 || erro_trigger !== 1'b0 || db_estado !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: echo=%b ocupado=%b erro=%b db=%b, expected 0 0 0 0000",
                     echo, ocupado, erro_trigger, db_estado);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_valid();
        int n;
        int w;
        bit busy_drop;
        distancia = 9'd25;
        pulse_trigger(12);
        tick();
        checks++;
        if (db_estado !== 4'b0010 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL valid_burst_entry: db=%b ocupado=%b, expected 0010 1", db_estado, ocupado);
        end
        wait_echo_rise(100, n);
        checks++;
        if (n !== 20) begin
            failures++;
            $display("FAIL valid_echo_delay: got %0d cycles, expected 20", n);
        end
        busy_drop = 1'b0;
        w = 0;
        while (echo === 1'b1 && w < 500) begin
            if (ocupado !== 1'b1 || db_estado !== 4'b0011) busy_drop = 1'b1;
            w++;
            tick();
        end
        checks++;
        if (w !== 100) begin
            failures++;
            $display("FAIL valid_echo_width: got %0d cycles, expected 100", w);
        end
        checks++;
        if (busy_drop !== 1'b0) begin
            failures++;
            $display("FAIL valid_busy_in_echo: got drop=%b, expected 0", busy_drop);
        end
        checks++;
        if (db_estado !== 4'b0100 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL valid_holdoff_entry: db=%b ocupado=%b, expected 0100 1", db_estado, ocupado);
        end
        wait_idle(200, n);
        checks++;
        if (n !== 50 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL valid_holdoff_len: got %0d cycles ocupado=%b, expected 50 0", n, ocupado);
        end
    endtask

    task automatic test_short_trigger();
        int n;
        distancia = 9'd25;
        pulse_trigger(9);
        tick();
        checks++;
        if (erro_trigger !== 1'b1 || db_estado !== 4'b0000) begin
            failures++;
            $display("FAIL short_err_pulse: erro=%b db=%b, expected 1 0000", erro_trigger, db_estado);
        end
        tick();
        checks++;
        if (erro_trigger !== 1'b0) begin
            failures++;
            $display("FAIL short_err_one_cycle: erro=%b, expected 0", erro_trigger);
        end
        wait_echo_rise(40, n);
        checks++;
        if (n !== 40 || db_estado !== 4'b0000) begin
            failures++;
            $display("FAIL short_no_echo: rise after %0d db=%b, expected none(40) 0000", n, db_estado);
        end
    endtask

    task automatic test_range();
        int dists [3] = '{0, 401, 400};
        int widths[3] = '{2000, 2000, 1600};
        int n;
        int w;
        for (int i = 0; i < 3; i++) begin
            distancia = 9'(dists[i]);
            pulse_trigger(10);
            tick();
            wait_echo_rise(100, n);
            measure_width(3000, w);
            checks++;
            if (w !== widths[i]) begin
                failures++;
                $display("FAIL range_width_d%0d: got %0d cycles, expected %0d", dists[i], w, widths[i]);
            end
            wait_idle(200, n);
        end
    endtask

    task automatic test_sem_eco();
        int n;
        bit echo_seen;
        bit err_seen;
        bit left_hold;
        distancia = 9'd25;
        sem_eco   = 1'b1;
        pulse_trigger(12);
        tick();
        sem_eco   = 1'b0;
        echo_seen = 1'b0;
        n = 0;
        while (db_estado === 4'b0010 && n < 100) begin
            if (echo !== 1'b0) echo_seen = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (n !== 20 || db_estado !== 4'b0100 || echo !== 1'b0 || echo_seen) begin
            failures++;
            $display("FAIL sem_eco_to_holdoff: after %0d db=%b echo=%b seen=%b, expected 20 0100 0 0",
                     n, db_estado, echo, echo_seen);
        end
        err_seen  = 1'b0;
        left_hold = 1'b0;
        trigger   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (erro_trigger !== 1'b0) err_seen = 1'b1;
            if (db_estado !== 4'b0100) left_hold = 1'b1;
        end
        trigger = 1'b0;
        tick();
        if (erro_trigger !== 1'b0) err_seen = 1'b1;
        if (db_estado !== 4'b0100) left_hold = 1'b1;
        checks++;
        if (err_seen || left_hold) begin
            failures++;
            $display("FAIL holdoff_ignores_trigger: err=%b left=%b, expected 0 0", err_seen, left_hold);
        end
        wait_idle(200, n);
        checks++;
        if (n !== 39) begin
            failures++;
            $display("FAIL sem_eco_holdoff_len: got %0d more cycles, expected 39", n);
        end
        distancia = 9'd1;
        pulse_trigger(10);
        tick();
        checks++;
        if (db_estado !== 4'b0010) begin
            failures++;
            $display("FAIL retrigger_accepted: db=%b, expected 0010", db_estado);
        end
        wait_idle(300, n);
    endtask

    task automatic test_stability();
        int n;
        int w;
        bit err_seen;
        distancia = 9'd25;
        pulse_trigger(12);
        tick();
        wait_echo_rise(100, n);
        err_seen = 1'b0;
        w = 0;
        while (echo === 1'b1 && w < 500) begin
            if (w == 10) distancia = 9'd3;
            if (w == 20) trigger = 1'b1;
            if (w == 35) trigger = 1'b0;
            if (erro_trigger !== 1'b0 || db_estado !== 4'b0011) err_seen = 1'b1;
            w++;
            tick();
        end
        trigger = 1'b0;
        checks++;
        if (w !== 100) begin
            failures++;
            $display("FAIL stable_echo_width: got %0d cycles, expected 100", w);
        end
        checks++;
        if (err_seen) begin
            failures++;
            $display("FAIL echo_ignores_trigger: got disturbance=%b, expected 0", err_seen);
        end
        wait_idle(200, n);
    endtask

    task automatic test_reset_mid();
        int n;
        int w;
        distancia = 9'd25;
        pulse_trigger(12);
        tick();
        wait_echo_rise(100, n);
        w = 1;
        while (w < 40) begin
            tick();
            w++;
        end
        reset = 1'b1;
        tick();
        checks++;
        if (echo !== 1'b0 || ocupado !== 1'b0 || db_estado !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_echo: echo=%b ocupado=%b db=%b, expected 0 0 0000",
                     echo, ocupado, db_estado);
        end
        reset = 1'b0;
        tick();
        distancia = 9'd2;
        pulse_trigger(10);
        tick();
        wait_echo_rise(100, n);
        measure_width(500, w);
        checks++;
        if (n !== 20 || w !== 8) begin
            failures++;
            $display("FAIL after_reset_d2: delay=%0d width=%0d, expected 20 8", n, w);
        end
        wait_idle(200, n);
    endtask

    initial begin
        reset     = 1'b1;
        trigger   = 1'b0;
        distancia = 9'd0;
        sem_eco   = 1'b0;
        test_reset();
        test_valid();
        test_short_trigger();
        test_range();
        test_sem_eco();
        test_stability();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
